// File: rtl/dmem_resp.sv
// ============================================================================
// Module  : dmem_resp
// Purpose : MEM-stage data-memory responder with fixed multi-cycle latency
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dmem_resp #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        memtoRegM,
  input  logic        memWriteM,
  input  logic [31:0] aluOutM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        misalignM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic                cap_st, cap_ld;
  logic [ADDR_W-1:0]   cap_idx;
  logic [31:0]         cap_data;
  logic [31:0]         mem [2**ADDR_W];

  logic                req, aligned, accept, commit;
  logic [ADDR_W-1:0]   in_idx;
  logic                commit_st, commit_ld;
  logic [ADDR_W-1:0]   commit_idx;
  logic [31:0]         commit_data;

  assign req     = memtoRegM | memWriteM;
  assign aligned = (aluOutM[1:0] == 2'b00);
  assign in_idx  = aluOutM[ADDR_W+1:2];
  assign accept  = (state == IDLE) && req && aligned;

  if (ADDR_W < 30) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^aluOutM[31:ADDR_W+2];
  end

  // Busy cycles stall on state alone so that inputs wandering mid-access
  // cannot shorten the hold; reset forces the hold low at once.
  assign stallM = clr && ((state == BUSY) || accept);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx = DONE;
            cnt_nx   = 4'd0;
          end else begin
            state_nx = BUSY;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_nx = 4'(cnt - 4'd1);
        if (cnt <= 4'd1) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // With single-cycle latency DONE is entered straight from IDLE, so the
  // commit must take the live inputs rather than the not-yet-captured copy.
  assign commit      = (state_nx == DONE) && (state != DONE);
  assign commit_st   = (state == IDLE) ? memWriteM : cap_st;
  assign commit_ld   = (state == IDLE) ? (memtoRegM & ~memWriteM) : cap_ld;
  assign commit_idx  = (state == IDLE) ? in_idx : cap_idx;
  assign commit_data = (state == IDLE) ? writeDataM : cap_data;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_st    <= 1'b0;
      cap_ld    <= 1'b0;
      cap_idx   <= '0;
      cap_data  <= 32'd0;
      readDataM <= 32'd0;
      misalignM <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      misalignM <= (state == IDLE) && req && !aligned;
      if (accept) begin
        cap_st   <= memWriteM;
        cap_ld   <= memtoRegM & ~memWriteM;
        cap_idx  <= in_idx;
        cap_data <= writeDataM;
      end
      if (commit && commit_ld) begin
        readDataM <= mem[commit_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr && commit && commit_st) begin
      mem[commit_idx] <= commit_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// ============================================================================
// Module  : tb_dmem_resp
// Purpose : Directed and randomized self-checking bench for dmem_resp
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_resp;

  logic        clk;
  logic        clr;
  logic        ld0, st0, ld1, st1;
  logic [31:0] a0, d0, a1, d1;
  logic [31:0] rd0, rd1;
  logic        stall0, stall1, mis0, mis1;

  int          n_cmp;
  int          n_bad;
  int          lat [2];
  logic [31:0] mdl [2][256];
  logic [31:0] rdm [2];

  dmem_resp #(.ADDR_W(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .clr(clr), .memtoRegM(ld0), .memWriteM(st0),
    .aluOutM(a0), .writeDataM(d0), .readDataM(rd0),
    .stallM(stall0), .misalignM(mis0)
  );

  dmem_resp #(.ADDR_W(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .clr(clr), .memtoRegM(ld1), .memWriteM(st1),
    .aluOutM(a1), .writeDataM(d1), .readDataM(rd1),
    .stallM(stall1), .misalignM(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      ld0 = ld; st0 = st; a0 = a; d0 = d;
    end else begin
      ld1 = ld; st1 = st; a1 = a; d1 = d;
    end
  endtask

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? stall0 : stall1;
  endfunction

  function automatic logic get_mis(input int sel);
    return (sel == 0) ? mis0 : mis1;
  endfunction

  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? rd0 : rd1;
  endfunction

  // Called a little after a falling edge; returns a little after a falling
  // edge with the inputs idle, so consecutive calls are back-to-back.
  task automatic access(input int sel, input logic ld, input logic st,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit chg);
    int n;
    logic [7:0] idx;
    idx = addr[9:2];
    set_in(sel, ld, st, addr, data);
    #1;
    if (addr[1:0] != 2'b00) begin
      check("mis_stall", {31'd0, get_stall(sel)}, 32'd0);
      @(negedge clk);
      set_in(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      check("mis_pulse", {31'd0, get_mis(sel)}, 32'd1);
      @(negedge clk);
      #1;
      check("mis_clear", {31'd0, get_mis(sel)}, 32'd0);
      check("mis_rd", get_rd(sel), rdm[sel]);
      return;
    end
    n = 0;
    while (get_stall(sel) && n < 40) begin
      n++;
      @(negedge clk);
      if (chg && n == 1) set_in(sel, ld, st, addr ^ 32'h20, ~data);
      #1;
    end
    check("stall_cycles", n, lat[sel]);
    if (st) mdl[sel][idx] = data;
    else if (ld) rdm[sel] = mdl[sel][idx];
    check("done_rd", get_rd(sel), rdm[sel]);
    check("done_mis", {31'd0, get_mis(sel)}, 32'd0);
    @(negedge clk);
    set_in(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
  endtask

  initial begin
    logic [31:0] addr, data;
    int r, slot;
    n_cmp = 0;
    n_bad = 0;
    lat[0] = 2;
    lat[1] = 1;
    rdm[0] = 32'd0;
    rdm[1] = 32'd0;
    clr = 1'b0;
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    check("rst_rd", rd0, 32'd0);
    check("rst_stall", {31'd0, stall0}, 32'd0);
    check("rst_mis", {31'd0, mis0}, 32'd0);
    check("rst_rd_l1", rd1, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    #1;

    // Prior contents, then a store abandoned by reset in the middle of BUSY
    access(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    set_in(0, 1'b0, 1'b1, 32'h10, 32'hAAAA_5555);
    #1;
    check("abort_req_stall", {31'd0, stall0}, 32'd1);
    @(negedge clk);
    #1;
    check("abort_busy_stall", {31'd0, stall0}, 32'd1);
    clr = 1'b0;
    #1;
    check("abort_stall", {31'd0, stall0}, 32'd0);
    check("abort_rd", rd0, 32'd0);
    rdm[0] = 32'd0;
    rdm[1] = 32'd0;
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Store then load, LATENCY=2
    access(0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    // Misaligned load and store are dropped
    access(0, 1'b1, 1'b0, 32'h42, 32'h0, 1'b0);
    access(0, 1'b0, 1'b1, 32'h43, 32'h99, 1'b0);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    // Address wrap and simultaneous load+store
    access(0, 1'b0, 1'b1, 32'h400, 32'h0000_0001, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    access(0, 1'b1, 1'b1, 32'h4, 32'h77, 1'b0);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);

    // Inputs wander after capture
    access(0, 1'b0, 1'b1, 32'hA0, 32'h5A5A_5A5A, 1'b0);
    access(0, 1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b1);
    access(0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'hA0, 32'h0, 1'b0);

    // LATENCY=1 instance
    access(1, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic over a set of pre-written slots
    for (int s = 0; s < 8; s++) begin
      access(0, 1'b0, 1'b1, 32'(s * 4), $urandom, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      r    = $urandom_range(0, 9);
      slot = $urandom_range(0, 7);
      addr = ($urandom & 32'hFFFF_FC00) | 32'(slot << 2);
      data = $urandom;
      if (r < 3)      access(0, 1'b0, 1'b1, addr, data, 1'(r == 0));
      else if (r < 7) access(0, 1'b1, 1'b0, addr, data, 1'(r == 3));
      else if (r < 9) access(0, 1'b1, 1'b1, addr, data, 1'b0);
      else            access(0, 1'($urandom_range(0, 1)), 1'b1,
                             addr | 32'($urandom_range(1, 3)), data, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
